song_sequencer: RTL and testbench

- Playback scheduler for the two 32-bit lane patterns produced by the song editor.
- When the game mode selects play, the block snapshots note1/note2 on start and runs a count-in.
- It then steps through bits 31 down to 0 at a tempo-derived rate, driving per-lane note outputs and a step strobe to the display/scoring logic.
- It supports pause, optional looping and abort on mode change.

---
 rtl/song_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_song_sequencer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/song_sequencer.sv
// Playback scheduler for two 32-bit lane patterns: count-in, then steps from
// bit 31 down to bit 0 at a tempo-derived rate. Supports pause, looping and
// abort when the game leaves play mode. All outputs are registered.
module song_sequencer #(
    parameter int unsigned STEP_CYCLES_BASE = 1_000_000,
    parameter int unsigned COUNT_IN_STEPS   = 3,
    parameter logic [2:0]  PLAY_MODE        = 3'd3
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic [2:0]  mode,
    input  logic        start,
    input  logic        pause,
    input  logic [31:0] note1,
    input  logic [31:0] note2,
    input  logic [1:0]  tempo_sel,
    input  logic        loop_en,
    output logic        lane1,
    output logic        lane2,
    output logic        step_pulse,
    output logic [4:0]  position,
    output logic [1:0]  countdown,
    output logic        paused,
    output logic [1:0]  state_out,
    output logic        song_done
);

    localparam int unsigned TW = $clog2(STEP_CYCLES_BASE + 1);
    localparam logic [TW-1:0] BaseCycles = TW'(STEP_CYCLES_BASE);
    localparam logic [1:0] CountInit = 2'(COUNT_IN_STEPS);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCountin = 2'd1,
        StPlay    = 2'd2,
        StDone    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   snap1_q, snap1_d;
    logic [31:0]   snap2_q, snap2_d;
    logic [TW-1:0] period_q, period_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          lane1_q, lane1_d;
    logic          lane2_q, lane2_d;
    logic          step_q, step_d;
    logic [4:0]    pos_q, pos_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          paused_q, paused_d;
    logic          done_q, done_d;

    logic          expiry;
    logic [4:0]    pos_next;

    assign expiry   = (timer_q == (period_q - TW'(1)));
    assign pos_next = pos_q - 5'd1;

    // Next-state logic: mode abort, start/pause handling and the step timer.
    always_comb begin
        state_d  = state_q;
        snap1_d  = snap1_q;
        snap2_d  = snap2_q;
        period_d = period_q;
        timer_d  = timer_q;
        lane1_d  = lane1_q;
        lane2_d  = lane2_q;
        step_d   = 1'b0;
        pos_d    = pos_q;
        cnt_d    = cnt_q;
        paused_d = paused_q;
        done_d   = done_q;

        if (mode != PLAY_MODE) begin
            state_d  = StIdle;
            snap1_d  = '0;
            snap2_d  = '0;
            period_d = '0;
            timer_d  = '0;
            lane1_d  = 1'b0;
            lane2_d  = 1'b0;
            pos_d    = 5'd31;
            cnt_d    = 2'd0;
            paused_d = 1'b0;
            done_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    // Pause is ignored here; a simultaneous start wins with paused=0.
                    if (start) begin
                        state_d  = StCountin;
                        snap1_d  = note1;
                        snap2_d  = note2;
                        period_d = BaseCycles >> tempo_sel;
                        timer_d  = '0;
                        lane1_d  = 1'b0;
                        lane2_d  = 1'b0;
                        pos_d    = 5'd31;
                        cnt_d    = CountInit;
                        paused_d = 1'b0;
                        done_d   = 1'b0;
                    end
                end
                StCountin, StPlay: begin
                    paused_d = paused_q ^ pause;
                    // Timer advances on the current pause flag, so a pause pulse
                    // freezes from the following cycle on.
                    if (!paused_q) begin
                        if (!expiry) begin
                            timer_d = timer_q + TW'(1);
                        end else begin
                            timer_d = '0;
                            if (state_q == StCountin) begin
                                if (cnt_q == 2'd1) begin
                                    state_d = StPlay;
                                    cnt_d   = 2'd0;
                                    pos_d   = 5'd31;
                                    lane1_d = snap1_q[31];
                                    lane2_d = snap2_q[31];
                                    step_d  = 1'b1;
                                end else begin
                                    cnt_d = cnt_q - 2'd1;
                                end
                            end else if (pos_q != 5'd0) begin
                                pos_d   = pos_next;
                                lane1_d = snap1_q[pos_next];
                                lane2_d = snap2_q[pos_next];
                                step_d  = 1'b1;
                            end else if (loop_en) begin
                                pos_d   = 5'd31;
                                lane1_d = snap1_q[31];
                                lane2_d = snap2_q[31];
                                step_d  = 1'b1;
                            end else begin
                                state_d  = StDone;
                                pos_d    = 5'd31;
                                lane1_d  = 1'b0;
                                lane2_d  = 1'b0;
                                paused_d = 1'b0;
                                done_d   = 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q  <= StIdle;
            snap1_q  <= '0;
            snap2_q  <= '0;
            period_q <= '0;
            timer_q  <= '0;
            lane1_q  <= 1'b0;
            lane2_q  <= 1'b0;
            step_q   <= 1'b0;
            pos_q    <= 5'd31;
            cnt_q    <= 2'd0;
            paused_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap1_q  <= snap1_d;
            snap2_q  <= snap2_d;
            period_q <= period_d;
            timer_q  <= timer_d;
            lane1_q  <= lane1_d;
            lane2_q  <= lane2_d;
            step_q   <= step_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            paused_q <= paused_d;
            done_q   <= done_d;
        end
    end

    assign lane1      = lane1_q;
    assign lane2      = lane2_q;
    assign step_pulse = step_q;
    assign position   = pos_q;
    assign countdown  = cnt_q;
    assign paused     = paused_q;
    assign state_out  = state_q;
    assign song_done  = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: vector table, directed corner-case
// sequences, and randomized stimulus against a tick-counting reference model.
module tb_song_sequencer;

    localparam int BASE = 8;
    localparam int NCI  = 2;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic [2:0]  mode = 3'd3;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [31:0] note1 = '0;
    logic [31:0] note2 = '0;
    logic [1:0]  tempo_sel = 2'd0;
    logic        loop_en = 1'b0;
    logic        lane1, lane2, step_pulse, paused, song_done;
    logic [4:0]  position;
    logic [1:0]  countdown, state_out;

    song_sequencer #(
        .STEP_CYCLES_BASE(BASE),
        .COUNT_IN_STEPS(NCI),
        .PLAY_MODE(3'd3)
    ) dut (
        .clk(clk), .Rst(Rst), .mode(mode), .start(start), .pause(pause),
        .note1(note1), .note2(note2), .tempo_sel(tempo_sel), .loop_en(loop_en),
        .lane1(lane1), .lane2(lane2), .step_pulse(step_pulse), .position(position),
        .countdown(countdown), .paused(paused), .state_out(state_out),
        .song_done(song_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // {state, countdown, position, lane1, lane2, step_pulse, paused, song_done}
    function automatic logic [14:0] mkv(input int st, input int cd, input int pos,
                                        input bit l1, input bit l2, input bit pu,
                                        input bit pa, input bit dn);
        return {2'(st), 2'(cd), 5'(pos), l1, l2, pu, pa, dn};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {state_out, countdown, position, lane1, lane2, step_pulse, paused, song_done};
    endfunction

    // Reference model: a song is described by the number of unpaused active
    // cycles since start; count-in beats and step boundaries follow from
    // division/modulo by the period.
    bit          m_active, m_done, m_paused, m_pulse;
    int          m_ticks, m_p, m_pos;
    logic [31:0] m_s1, m_s2;

    task automatic model_step();
        m_pulse = 1'b0;
        if (Rst || mode != 3'd3) begin
            m_active = 0; m_done = 0; m_paused = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_done = 0; m_paused = 0; m_ticks = 0;
                m_p = BASE >> tempo_sel; m_s1 = note1; m_s2 = note2; m_pos = 31;
            end
        end else begin
            bit was_paused;
            was_paused = m_paused;
            if (pause) m_paused = !m_paused;
            if (!was_paused) begin
                if (m_ticks % m_p == m_p - 1) begin
                    int beat;
                    beat = m_ticks / m_p;
                    if (beat == NCI - 1) begin
                        m_pos = 31; m_pulse = 1;
                    end else if (beat >= NCI) begin
                        if (m_pos > 0) begin
                            m_pos--; m_pulse = 1;
                        end else if (loop_en) begin
                            m_pos = 31; m_pulse = 1;
                        end else begin
                            m_active = 0; m_done = 1; m_paused = 0;
                        end
                    end
                end
                m_ticks++;
            end
        end
    endtask

    function automatic logic [14:0] model_vec();
        int st, cd, pos;
        bit l1, l2;
        if (!m_active) st = m_done ? 3 : 0;
        else st = (m_ticks / m_p < NCI) ? 1 : 2;
        cd  = (st == 1) ? NCI - m_ticks / m_p : 0;
        pos = (st == 2) ? m_pos : 31;
        l1  = (st == 2) ? m_s1[pos] : 1'b0;
        l2  = (st == 2) ? m_s2[pos] : 1'b0;
        return mkv(st, cd, pos, l1, l2, m_pulse, m_paused, m_done);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_pulse(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!step_pulse && n < 200);
    endtask

    task automatic wait_state(input logic [1:0] st, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (state_out != st && n < 200);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  mode;
        logic        start;
        logic        pause;
        logic [31:0] n1;
        logic [1:0]  tempo;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int n, bad;
        bit done_seen;

        // Table: tempo_sel=3 gives a 1-cycle step period; note2 stays 4000_0000.
        vecs[0]  = '{1'b1, 3'd3, 1'b0, 1'b0, 32'h8000_0001, 2'd3, mkv(0, 0, 31, 0, 0, 0, 0, 0)};
        vecs[1]  = '{1'b0, 3'd2, 1'b1, 1'b0, 32'h8000_0001, 2'd3, mkv(0, 0, 31, 0, 0, 0, 0, 0)};
        vecs[2]  = '{1'b0, 3'd3, 1'b1, 1'b1, 32'h8000_0001, 2'd3, mkv(1, 2, 31, 0, 0, 0, 0, 0)};
        vecs[3]  = '{1'b0, 3'd3, 1'b0, 1'b0, 32'h8000_0001, 2'd3, mkv(1, 1, 31, 0, 0, 0, 0, 0)};
        vecs[4]  = '{1'b0, 3'd3, 1'b0, 1'b0, 32'h8000_0001, 2'd3, mkv(2, 0, 31, 1, 0, 1, 0, 0)};
        vecs[5]  = '{1'b0, 3'd3, 1'b0, 1'b1, 32'h8000_0001, 2'd3, mkv(2, 0, 30, 0, 1, 1, 1, 0)};
        vecs[6]  = '{1'b0, 3'd3, 1'b0, 1'b0, 32'h8000_0001, 2'd3, mkv(2, 0, 30, 0, 1, 0, 1, 0)};
        vecs[7]  = '{1'b0, 3'd3, 1'b0, 1'b1, 32'h8000_0001, 2'd3, mkv(2, 0, 30, 0, 1, 0, 0, 0)};
        vecs[8]  = '{1'b0, 3'd3, 1'b0, 1'b0, 32'hFFFF_FFFF, 2'd3, mkv(2, 0, 29, 0, 0, 1, 0, 0)};
        vecs[9]  = '{1'b0, 3'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 2'd3, mkv(2, 0, 28, 0, 0, 1, 0, 0)};
        vecs[10] = '{1'b0, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 2'd3, mkv(0, 0, 31, 0, 0, 0, 0, 0)};

        note2 = 32'h4000_0000;
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            Rst = vecs[i].rst; mode = vecs[i].mode; start = vecs[i].start;
            pause = vecs[i].pause; note1 = vecs[i].n1; tempo_sel = vecs[i].tempo;
            tick();
            chk($sformatf("vec%0d", i), 32'(dut_vec()), 32'(vecs[i].exp));
        end
        Rst = 0; start = 0; pause = 0; mode = 3'd3;

        // Full song at tempo 0, with a pause at position 20 and a note change.
        note1 = 32'h8000_0001; tempo_sel = 2'd0; loop_en = 0;
        pulse_start();
        chk("countin entry state", 32'(state_out), 32'd1);
        chk("countin entry cd", 32'(countdown), 32'd2);
        repeat (7) tick();
        chk("cd before first beat", 32'(countdown), 32'd2);
        tick();
        chk("cd after first beat", 32'(countdown), 32'd1);
        wait_pulse(n);
        chk("first pulse latency", 32'(8 + n), 32'd16);
        chk("first step", 32'(dut_vec()), 32'(mkv(2, 0, 31, 1, 0, 1, 0, 0)));
        for (int p = 30; p >= 0; p--) begin
            wait_pulse(n);
            chk($sformatf("spacing p%0d", p), 32'(n), (p == 19) ? 32'd4 : 32'd8);
            chk($sformatf("position p%0d", p), 32'(position), 32'(p));
            if (p == 30) begin
                chk("second step lanes", 32'({lane1, lane2}), 32'b01);
                note1 = 32'h0;
            end
            if (p == 20) begin
                repeat (3) tick();
                pause = 1; tick(); pause = 0;
                bad = 0;
                repeat (50) begin
                    tick();
                    if (step_pulse || position != 5'd20 || !paused) bad++;
                end
                chk("pause hold", 32'(bad), 32'd0);
                pause = 1; tick(); pause = 0;
                chk("resume paused", 32'(paused), 32'd0);
            end
            if (p == 0) chk("snapshot lane1 p0", 32'(lane1), 32'd1);
        end
        repeat (8) tick();
        chk("song end", 32'(dut_vec()), 32'(mkv(3, 0, 31, 0, 0, 0, 0, 1)));

        // Restart from DONE at tempo 2: 4 count-in cycles + 64 song cycles.
        note1 = 32'h8000_0001; tempo_sel = 2'd2;
        pulse_start();
        chk("restart state", 32'({state_out, song_done}), 32'b010);
        wait_pulse(n);
        chk("tempo2 countin", 32'(n), 32'd4);
        wait_pulse(n);
        chk("tempo2 spacing", 32'(n), 32'd2);
        wait_state(2'd3, n);
        chk("tempo2 total", 32'(4 + 2 + n), 32'd68);

        // Looping at tempo 3.
        tempo_sel = 2'd3; loop_en = 1;
        pulse_start();
        done_seen = 0;
        wait_pulse(n);
        chk("loop first pos", 32'(position), 32'd31);
        repeat (31) begin
            tick();
            if (song_done) done_seen = 1;
        end
        chk("loop pos0", 32'(position), 32'd0);
        tick();
        chk("loop wrap", 32'(dut_vec()), 32'(mkv(2, 0, 31, 1, 0, 1, 0, 0)));
        chk("loop no done", 32'(done_seen || song_done), 32'd0);

        // Mode abort while paused in PLAY; start ignored outside play mode.
        pause = 1; tick(); pause = 0;
        chk("paused before abort", 32'(paused), 32'd1);
        mode = 3'd2; tick();
        chk("mode abort", 32'(dut_vec()), 32'(mkv(0, 0, 31, 0, 0, 0, 0, 0)));
        pulse_start();
        chk("start ignored mode2", 32'(state_out), 32'd0);
        mode = 3'd3;

        // Reset during count-in with countdown=1.
        tempo_sel = 2'd0; loop_en = 0;
        pulse_start();
        repeat (8) tick();
        chk("cd1 before reset", 32'(countdown), 32'd1);
        Rst = 1; tick(); Rst = 0;
        chk("reset in countin", 32'(dut_vec()), 32'(mkv(0, 0, 31, 0, 0, 0, 0, 0)));

        // Randomized stimulus against the reference model.
        for (int c = 0; c < 4000; c++) begin
            Rst       = ($urandom_range(199) == 0);
            mode      = ($urandom_range(49) == 0) ? 3'($urandom_range(7)) : 3'd3;
            start     = ($urandom_range(19) == 0);
            pause     = ($urandom_range(29) == 0);
            note1     = $urandom;
            note2     = $urandom;
            tempo_sel = 2'($urandom_range(3, 1));
            if ($urandom_range(99) == 0) loop_en = !loop_en;
            tick();
            chk($sformatf("model c%0d", c), 32'(dut_vec()), 32'(model_vec()));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
